// File: rtl/pipeline_controller_pkg.sv
// Shared types for the five-stage rv32i pipeline controller.
package pipeline_controller_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_t;

  typedef enum logic [1:0] {
    REG_WRITE_FROM_COMPUTE = 2'd0,
    REG_WRITE_FROM_MEMORY  = 2'd1,
    REG_WRITE_FROM_PC      = 2'd2,
    REG_WRITE_FROM_IMM     = 2'd3
  } reg_write_source;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use and taken-jump detection between decode and compute.
module pipeline_controller_hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  v_d_i,
  input  logic                  v_c_i,
  input  logic                  d_rs1_used_i,
  input  logic                  d_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] d_rs1_i,
  input  logic [REG_ADDR_W-1:0] d_rs2_i,
  input  logic                  c_rd_enable_i,
  input  logic                  c_rd_is_mem_i,
  input  logic [REG_ADDR_W-1:0] c_rd_i,
  input  logic                  c_jump_taken_i,
  output logic                  lu_c_o,
  output logic                  jt_c_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic load_in_c;

  assign rs1_hit   = d_rs1_used_i && (d_rs1_i == c_rd_i);
  assign rs2_hit   = d_rs2_used_i && (d_rs2_i == c_rd_i);
  // x0 never carries a real value, so a load into it cannot create a hazard
  assign load_in_c = v_c_i && c_rd_enable_i && c_rd_is_mem_i && (c_rd_i != '0);

  assign lu_c_o = v_d_i && load_in_c && (rs1_hit || rs2_hit);
  assign jt_c_o = v_c_i && c_jump_taken_i;

endmodule

// File: rtl/pipeline_controller.sv
// Stage-valid tracking, hazard stalls, jump squash, memory freeze and
// performance counters for the F/D/C/M/W pipeline.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_rs1_used,
  input  logic                  d_rs2_used,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic                  c_rd_enable,
  input  logic                  c_rd_is_load,
  input  logic [REG_ADDR_W-1:0] c_rd,
  input  logic                  c_jump_taken,
  input  logic [XLEN-1:0]       c_jump_addr,
  input  logic                  m_access,
  input  logic                  mem_ready,
  output logic                  fetch_enable,
  output logic                  decode_enable,
  output logic                  compute_enable,
  output logic                  mem_enable,
  output logic                  wb_enable,
  output logic                  hold_fd,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       pc_redirect_addr,
  output logic [CNT_W-1:0]      instret,
  output logic [CNT_W-1:0]      bubbles
);

  pipe_state_t      state_q, state_d;
  logic             v_d_q, v_c_q, v_m_q, v_w_q;
  logic             v_d_d, v_c_d, v_m_d, v_w_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] bubbles_q, bubbles_d;

  reg_write_source  c_src;
  logic             c_is_mem;
  logic             lu;
  logic             jt;
  logic             mem_wait;

  assign c_src    = c_rd_is_load ? REG_WRITE_FROM_MEMORY : REG_WRITE_FROM_COMPUTE;
  assign c_is_mem = (c_src == REG_WRITE_FROM_MEMORY);

  pipeline_controller_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .v_d_i          (v_d_q),
    .v_c_i          (v_c_q),
    .d_rs1_used_i   (d_rs1_used),
    .d_rs2_used_i   (d_rs2_used),
    .d_rs1_i        (d_rs1),
    .d_rs2_i        (d_rs2),
    .c_rd_enable_i  (c_rd_enable),
    .c_rd_is_mem_i  (c_is_mem),
    .c_rd_i         (c_rd),
    .c_jump_taken_i (c_jump_taken),
    .lu_c_o         (lu),
    .jt_c_o         (jt)
  );

  assign mem_wait       = v_m_q && m_access && !mem_ready;
  assign fetch_enable   = !reset;
  assign decode_enable  = v_d_q;
  assign compute_enable = v_c_q;
  assign mem_enable     = v_m_q;
  assign wb_enable      = v_w_q && !mem_wait;
  assign instret        = instret_q;
  assign bubbles        = bubbles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      v_d_q     <= 1'b0;
      v_c_q     <= 1'b0;
      v_m_q     <= 1'b0;
      v_w_q     <= 1'b0;
      instret_q <= '0;
      bubbles_q <= '0;
    end else begin
      state_q   <= state_d;
      v_d_q     <= v_d_d;
      v_c_q     <= v_c_d;
      v_m_q     <= v_m_d;
      v_w_q     <= v_w_d;
      instret_q <= instret_d;
      bubbles_q <= bubbles_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    v_d_d            = v_d_q;
    v_c_d            = v_c_q;
    v_m_d            = v_m_q;
    v_w_d            = v_w_q;
    instret_d        = instret_q;
    bubbles_d        = bubbles_q;
    hold_fd          = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;

    case (state_q)
      RUN:      if (mem_wait)  state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:                 state_d = RUN;
    endcase

    // A pending jump stays in C while frozen and redirects once memory releases
    if (mem_wait) begin
      hold_fd = 1'b1;
    end else begin
      v_w_d = v_m_q;
      v_m_d = v_c_q;
      if (jt) begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = c_jump_addr;
        v_d_d            = 1'b0;
        v_c_d            = 1'b0;
      end else if (lu) begin
        hold_fd = 1'b1;
        v_c_d   = 1'b0;
      end else begin
        v_d_d = 1'b1;
        v_c_d = v_d_q;
      end
      if (!v_c_d) bubbles_d = bubbles_q + CNT_W'(1);
    end

    if (wb_enable) instret_d = instret_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized check of pipeline_controller against an instruction-movement model.
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 8;
  localparam int          CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          d_rs1_used, d_rs2_used;
  logic [RW-1:0] d_rs1, d_rs2;
  logic          c_rd_enable, c_rd_is_load;
  logic [RW-1:0] c_rd;
  logic          c_jump_taken;
  logic [31:0]   c_jump_addr;
  logic          m_access, mem_ready;
  logic          fetch_enable, decode_enable, compute_enable, mem_enable, wb_enable;
  logic          hold_fd, pc_redirect;
  logic [31:0]   pc_redirect_addr;
  logic [CW-1:0] instret, bubbles;

  always #5 clk = ~clk;

  pipeline_controller #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .d_rs1_used       (d_rs1_used),
    .d_rs2_used       (d_rs2_used),
    .d_rs1            (d_rs1),
    .d_rs2            (d_rs2),
    .c_rd_enable      (c_rd_enable),
    .c_rd_is_load     (c_rd_is_load),
    .c_rd             (c_rd),
    .c_jump_taken     (c_jump_taken),
    .c_jump_addr      (c_jump_addr),
    .m_access         (m_access),
    .mem_ready        (mem_ready),
    .fetch_enable     (fetch_enable),
    .decode_enable    (decode_enable),
    .compute_enable   (compute_enable),
    .mem_enable       (mem_enable),
    .wb_enable        (wb_enable),
    .hold_fd          (hold_fd),
    .pc_redirect      (pc_redirect),
    .pc_redirect_addr (pc_redirect_addr),
    .instret          (instret),
    .bubbles          (bubbles)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: which instruction tag occupies D/C/M/W (0 = empty slot)
  int occ_d, occ_c, occ_m, occ_w, next_tag;
  int m_instret, m_bubbles;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    occ_d = 0; occ_c = 0; occ_m = 0; occ_w = 0;
    m_instret = 0; m_bubbles = 0;
  endtask

  task automatic quiet();
    d_rs1_used = 1'b0; d_rs2_used = 1'b0; d_rs1 = '0; d_rs2 = '0;
    c_rd_enable = 1'b0; c_rd_is_load = 1'b0; c_rd = '0;
    c_jump_taken = 1'b0; c_jump_addr = '0;
    m_access = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_fetch",   64'(fetch_enable),     64'(0));
    chk("rst_decode",  64'(decode_enable),    64'(0));
    chk("rst_compute", 64'(compute_enable),   64'(0));
    chk("rst_mem",     64'(mem_enable),       64'(0));
    chk("rst_wb",      64'(wb_enable),        64'(0));
    chk("rst_hold",    64'(hold_fd),          64'(0));
    chk("rst_redir",   64'(pc_redirect),      64'(0));
    chk("rst_addr",    64'(pc_redirect_addr), 64'(0));
    chk("rst_instret", 64'(instret),          64'(0));
    chk("rst_bubbles", 64'(bubbles),          64'(0));
  endtask

  // Inputs are already driven; check this cycle, then move the model to the next
  task automatic step();
    bit mw, lu, jt;
    #3;
    mw = (occ_m != 0) && m_access && !mem_ready;
    lu = (occ_d != 0) && (occ_c != 0) && c_rd_enable && c_rd_is_load && (c_rd != 0) &&
         ((d_rs1_used && d_rs1 == c_rd) || (d_rs2_used && d_rs2 == c_rd));
    jt = (occ_c != 0) && c_jump_taken;

    chk("fetch_enable",   64'(fetch_enable),   64'(1));
    chk("decode_enable",  64'(decode_enable),  64'(occ_d != 0));
    chk("compute_enable", 64'(compute_enable), 64'(occ_c != 0));
    chk("mem_enable",     64'(mem_enable),     64'(occ_m != 0));
    chk("wb_enable",      64'(wb_enable),      64'((occ_w != 0) && !mw));
    chk("hold_fd",        64'(hold_fd),        64'(mw || (lu && !jt)));
    chk("pc_redirect",    64'(pc_redirect),    64'(jt && !mw));
    chk("pc_redirect_addr", 64'(pc_redirect_addr), (jt && !mw) ? 64'(c_jump_addr) : 64'(0));
    chk("instret",        64'(instret),        64'(m_instret));
    chk("bubbles",        64'(bubbles),        64'(m_bubbles));

    if (occ_w != 0 && !mw) m_instret = (m_instret + 1) % CNT_MOD;
    if (!mw) begin
      occ_w = occ_m;
      occ_m = occ_c;
      if (jt) begin
        occ_c = 0;
        occ_d = 0;
      end else if (lu) begin
        occ_c = 0;
      end else begin
        occ_c = occ_d;
        occ_d = next_tag;
        next_tag++;
      end
      if (occ_c == 0) m_bubbles = (m_bubbles + 1) % CNT_MOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    next_tag = 1;
    quiet();
    model_reset();
    reset = 1'b1;
    #2;
    chk_reset_vals();
    release_reset();

    // Fill with plain ALU instructions
    repeat (7) step();

    // Load x5 in C, D reads x5: one bubble
    c_rd_enable = 1'b1; c_rd_is_load = 1'b1; c_rd = 5'd5; d_rs1_used = 1'b1; d_rs1 = 5'd5;
    step();
    quiet();
    repeat (2) step();
    // Same with rd = x0: no stall
    c_rd_enable = 1'b1; c_rd_is_load = 1'b1; c_rd = 5'd0; d_rs1_used = 1'b1; d_rs1 = 5'd0;
    step();
    quiet();
    repeat (2) step();

    // Taken jump to 0x40
    c_jump_taken = 1'b1; c_jump_addr = 32'h40;
    step();
    quiet();
    repeat (4) step();

    // Memory stall for 3 cycles with a jump waiting in C
    m_access = 1'b1; mem_ready = 1'b0; c_jump_taken = 1'b1; c_jump_addr = 32'h80;
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    quiet();
    repeat (4) step();

    // Jump and load-use together: jump wins
    c_jump_taken = 1'b1; c_jump_addr = 32'h100;
    c_rd_enable = 1'b1; c_rd_is_load = 1'b1; c_rd = 5'd7; d_rs2_used = 1'b1; d_rs2 = 5'd7;
    step();
    quiet();
    repeat (4) step();

    // Asynchronous reset in the middle of a memory stall
    m_access = 1'b1; mem_ready = 1'b0; c_jump_taken = 1'b1; c_jump_addr = 32'hC0;
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    quiet();
    release_reset();
    repeat (6) step();

    // Random traffic; the 8-bit counters wrap several times
    for (int i = 0; i < 3000; i++) begin
      d_rs1_used   = 1'($urandom_range(0, 1));
      d_rs2_used   = 1'($urandom_range(0, 1));
      d_rs1        = RW'($urandom_range(0, 3));
      d_rs2        = RW'($urandom_range(0, 3));
      c_rd_enable  = 1'($urandom_range(0, 1));
      c_rd_is_load = 1'($urandom_range(0, 1));
      c_rd         = RW'($urandom_range(0, 3));
      c_jump_taken = ($urandom_range(0, 7) == 0);
      c_jump_addr  = $urandom;
      m_access     = 1'($urandom_range(0, 1));
      mem_ready    = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
